// File: rtl/ats21_pkg.sv
// ATS21 receive front end: shared opcode/status/state types and
// instruction field bit positions.
package ats21_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SET_CLK   = 3'b001,
        OP_TOG_BC    = 3'b010,
        OP_SET_MODE  = 3'b011,
        OP_ILLEGAL   = 3'b100,
        OP_SET_ALARM = 3'b101,
        OP_SET_CDOWN = 3'b110,
        OP_TOG_AT    = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_ACCEPT  = 2'b01,
        STAT_ILLEGAL = 2'b10,
        STAT_BUSY    = 2'b11
    } stat_e;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_LOW     = 3'd1,
        RX_ISSUE_A = 3'd2,
        RX_ISSUE_B = 3'd3,
        RX_DONE    = 3'd4
    } rx_state_e;

    // Bit positions within the 32-bit {upper, lower} instruction word.
    localparam int unsigned OP_MSB      = 31;
    localparam int unsigned OP_LSB      = 29;
    localparam int unsigned CLK_ID_MSB  = 28;
    localparam int unsigned CLK_ID_LSB  = 25;
    localparam int unsigned ALM_ID_MSB  = 28;
    localparam int unsigned ALM_ID_LSB  = 24;
    localparam int unsigned MODE_MSB    = 27;
    localparam int unsigned MODE_LSB    = 24;
    localparam int unsigned FLAG_BIT    = 23;
    localparam int unsigned RATE_MSB    = 23;
    localparam int unsigned RATE_LSB    = 22;
    localparam int unsigned ALM_CLK_MSB = 19;
    localparam int unsigned ALM_CLK_LSB = 16;
    localparam int unsigned VALUE_MSB   = 15;
    localparam int unsigned VALUE_LSB   = 0;

    // NOP and ILLEGAL never reach the core; every other opcode is issued.
    function automatic logic op_is_queued(input logic [2:0] op);
        return !((op == OP_NOP) || (op == OP_ILLEGAL));
    endfunction

endpackage

// File: rtl/ats21_cmd_decode.sv
// ATS21 instruction decoder: splits a 32-bit instruction word into the
// opcode and the opcode-dependent id/flag/aux/value fields.
module ats21_cmd_decode
    import ats21_pkg::*;
(
    input  logic [31:0] word,
    output logic [2:0]  op,
    output logic [4:0]  id,
    output logic        flag,
    output logic [3:0]  aux,
    output logic [15:0] value
);

    // Bits [21:20] carry no field for any opcode.
    logic unused_bits;
    assign unused_bits = ^word[21:20];

    // Field extraction; fields not defined for an opcode read as zero.
    always_comb begin
        op    = word[OP_MSB:OP_LSB];
        id    = '0;
        flag  = 1'b0;
        aux   = '0;
        value = '0;
        case (opcode_e'(op))
            OP_SET_CLK: begin
                id    = {1'b0, word[CLK_ID_MSB:CLK_ID_LSB]};
                flag  = word[FLAG_BIT];
                aux   = {2'b00, word[RATE_MSB:RATE_LSB]};
                value = word[VALUE_MSB:VALUE_LSB];
            end
            OP_TOG_BC: begin
                id    = {1'b0, word[CLK_ID_MSB:CLK_ID_LSB]};
                flag  = word[FLAG_BIT];
            end
            OP_SET_MODE: begin
                flag  = word[FLAG_BIT];
                aux   = word[MODE_MSB:MODE_LSB];
            end
            OP_SET_ALARM, OP_SET_CDOWN: begin
                id    = word[ALM_ID_MSB:ALM_ID_LSB];
                flag  = word[FLAG_BIT];
                aux   = word[ALM_CLK_MSB:ALM_CLK_LSB];
                value = word[VALUE_MSB:VALUE_LSB];
            end
            OP_TOG_AT: begin
                id    = word[ALM_ID_MSB:ALM_ID_LSB];
                flag  = word[FLAG_BIT];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ats21_cmd_rx.sv
// ATS21 receive front end: captures two-word instructions from clients A
// and B, decodes them and issues them one at a time to the core over a
// valid/ready handshake, reporting progress on ready/stat.
module ats21_cmd_rx
    import ats21_pkg::*;
#(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [WORD_W-1:0] ctrlA,
    input  logic [WORD_W-1:0] ctrlB,
    output logic              ready,
    output logic [1:0]        stat,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_client,
    output logic [2:0]        cmd_op,
    output logic [4:0]        cmd_id,
    output logic              cmd_flag,
    output logic [3:0]        cmd_aux,
    output logic [WORD_W-1:0] cmd_value
);

    // Last stall cycle index before the pending command is dropped.
    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    rx_state_e         state, state_nxt;
    stat_e             stat_q, stat_nxt;
    logic [WORD_W-1:0] hi_a, hi_b, lo_a, lo_b;
    logic              queued_a, queued_b;
    logic [3:0]        timer;
    logic              in_issue, handshake, drop, busy_req, illegal_seen;
    logic              queue_a_nxt, queue_b_nxt;

    logic [2*WORD_W-1:0] dec_word;
    logic [2:0]          dec_op;
    logic [4:0]          dec_id;
    logic                dec_flag;
    logic [3:0]          dec_aux;
    logic [15:0]         dec_value;

    assign in_issue     = (state == RX_ISSUE_A) || (state == RX_ISSUE_B);
    assign queue_a_nxt  = op_is_queued(hi_a[WORD_W-1 -: 3]);
    assign queue_b_nxt  = op_is_queued(hi_b[WORD_W-1 -: 3]);
    assign illegal_seen = (state == RX_LOW) &&
                          ((hi_a[WORD_W-1 -: 3] == OP_ILLEGAL) ||
                           (hi_b[WORD_W-1 -: 3] == OP_ILLEGAL));
    // A req in the LOW cycle is the data phase, not a new request.
    assign busy_req     = req && !ready && (state != RX_LOW);

    // Next-state, handshake/timeout detection and status priority.
    always_comb begin
        state_nxt = state;
        stat_nxt  = STAT_OK;
        handshake = 1'b0;
        drop      = 1'b0;
        case (state)
            RX_IDLE: begin
                if (req) state_nxt = RX_LOW;
            end
            RX_LOW: begin
                if (queue_a_nxt)      state_nxt = RX_ISSUE_A;
                else if (queue_b_nxt) state_nxt = RX_ISSUE_B;
                else                  state_nxt = RX_DONE;
            end
            RX_ISSUE_A, RX_ISSUE_B: begin
                if (cmd_ready)                 handshake = 1'b1;
                else if (timer == TIMER_LAST)  drop      = 1'b1;
                if (handshake || drop) begin
                    if ((state == RX_ISSUE_A) && queued_b) state_nxt = RX_ISSUE_B;
                    else                                   state_nxt = RX_DONE;
                end
            end
            RX_DONE: begin
                state_nxt = RX_IDLE;
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
        if (busy_req || drop)  stat_nxt = STAT_BUSY;
        else if (illegal_seen) stat_nxt = STAT_ILLEGAL;
        else if (handshake)    stat_nxt = STAT_ACCEPT;
    end

    // State, status and host ready registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RX_IDLE;
            stat_q <= STAT_OK;
            ready  <= 1'b1;
        end else begin
            state  <= state_nxt;
            stat_q <= stat_nxt;
            if ((state == RX_IDLE) && req) ready <= 1'b0;
            else if (state == RX_DONE)     ready <= 1'b1;
        end
    end

    // Instruction holding registers and per-client queue flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_a     <= '0;
            hi_b     <= '0;
            lo_a     <= '0;
            lo_b     <= '0;
            queued_a <= 1'b0;
            queued_b <= 1'b0;
        end else begin
            if ((state == RX_IDLE) && req) begin
                hi_a <= ctrlA;
                hi_b <= ctrlB;
            end
            if (state == RX_LOW) begin
                lo_a     <= ctrlA;
                lo_b     <= ctrlB;
                queued_a <= queue_a_nxt;
                queued_b <= queue_b_nxt;
            end
        end
    end

    // Stall timer: restarts on every issue entry, saturates while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if ((state_nxt != state) &&
                     ((state_nxt == RX_ISSUE_A) || (state_nxt == RX_ISSUE_B))) begin
            timer <= '0;
        end else if (in_issue && (timer != '1)) begin
            timer <= timer + 4'd1;
        end
    end

    assign dec_word = (state == RX_ISSUE_B) ? {hi_b, lo_b} : {hi_a, lo_a};

    ats21_cmd_decode u_decode (
        .word  (dec_word),
        .op    (dec_op),
        .id    (dec_id),
        .flag  (dec_flag),
        .aux   (dec_aux),
        .value (dec_value)
    );

    // cmd_valid follows the state register, so an asynchronous reset drops it at once.
    assign cmd_valid  = in_issue;
    assign cmd_client = (state == RX_ISSUE_B);
    assign cmd_op     = cmd_valid ? dec_op    : '0;
    assign cmd_id     = cmd_valid ? dec_id    : '0;
    assign cmd_flag   = cmd_valid ? dec_flag  : 1'b0;
    assign cmd_aux    = cmd_valid ? dec_aux   : '0;
    assign cmd_value  = cmd_valid ? dec_value : '0;
    assign stat       = stat_q;

endmodule

// File: tb/tb_ats21_cmd_rx.sv
// Directed self-checking bench for ats21_cmd_rx.
module tb_ats21_cmd_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [15:0] ctrlA, ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_client;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_id;
    logic        cmd_flag;
    logic [3:0]  cmd_aux;
    logic [15:0] cmd_value;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    ats21_cmd_rx #(.WORD_W(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .ctrlA      (ctrlA),
        .ctrlB      (ctrlB),
        .ready      (ready),
        .stat       (stat),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_client (cmd_client),
        .cmd_op     (cmd_op),
        .cmd_id     (cmd_id),
        .cmd_flag   (cmd_flag),
        .cmd_aux    (cmd_aux),
        .cmd_value  (cmd_value)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic client, input logic [2:0] op,
                             input logic [4:0] id, input logic flag, input logic [3:0] aux,
                             input logic [15:0] value);
        check({tag, "_valid"},  32'(cmd_valid),  32'(1'b1));
        check({tag, "_client"}, 32'(cmd_client), 32'(client));
        check({tag, "_op"},     32'(cmd_op),     32'(op));
        check({tag, "_id"},     32'(cmd_id),     32'(id));
        check({tag, "_flag"},   32'(cmd_flag),   32'(flag));
        check({tag, "_aux"},    32'(cmd_aux),    32'(aux));
        check({tag, "_value"},  32'(cmd_value),  32'(value));
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 1'b0;
        ctrlA     = '0;
        ctrlB     = '0;
        cmd_ready = 1'b1;

        // 1: reset
        repeat (4) tick();
        check("rst_ready", 32'(ready),     32'd1);
        check("rst_stat",  32'(stat),      32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_op",    32'(cmd_op),    32'd0);
        reset_n = 1'b1;
        tick();

        // 2: set-clock pair, both clients, cmd_ready high
        req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h2240;
        tick();                                   // N+1: LOW
        req = 1'b0; ctrlA = 16'h0000; ctrlB = 16'h0000;
        check("p_low_ready", 32'(ready),     32'd0);
        check("p_low_valid", 32'(cmd_valid), 32'd0);
        tick();                                   // N+2: A issued
        check_cmd("p_a", 1'b0, 3'd1, 5'd0, 1'b0, 4'd0, 16'h0000);
        tick();                                   // N+3: B issued
        check_cmd("p_b", 1'b1, 3'd1, 5'd1, 1'b0, 4'd1, 16'h0000);
        check("p_b_stat", 32'(stat), 32'd1);
        tick();                                   // N+4: DONE
        check("p_done_valid", 32'(cmd_valid), 32'd0);
        check("p_done_stat",  32'(stat),      32'd1);
        tick();                                   // N+5: IDLE
        check("p_idle_ready", 32'(ready), 32'd1);
        check("p_idle_stat",  32'(stat),  32'd0);

        // 3: alarm on A only, B is NOP
        req = 1'b1; ctrlA = 16'hA080; ctrlB = 16'h0000;
        tick();
        req = 1'b0; ctrlA = 16'h0090; ctrlB = 16'h0000;
        tick();
        check_cmd("alm", 1'b0, 3'd5, 5'd0, 1'b1, 4'd0, 16'h0090);
        tick();
        check("alm_noB_valid", 32'(cmd_valid), 32'd0);
        check("alm_stat",      32'(stat),      32'd1);
        tick();
        check("alm_ready", 32'(ready), 32'd1);

        // 4: countdown, stalled 3 cycles, accepted in the 4th
        req = 1'b1; ctrlA = 16'hC102; ctrlB = 16'h0000;
        tick();
        req = 1'b0; ctrlA = 16'h0010; cmd_ready = 1'b0;
        tick();
        check_cmd("cd_s1", 1'b0, 3'd6, 5'd1, 1'b0, 4'd2, 16'h0010);
        tick();
        check_cmd("cd_s2", 1'b0, 3'd6, 5'd1, 1'b0, 4'd2, 16'h0010);
        check("cd_s2_stat", 32'(stat), 32'd0);
        tick();
        check_cmd("cd_s3", 1'b0, 3'd6, 5'd1, 1'b0, 4'd2, 16'h0010);
        tick();
        check_cmd("cd_acc", 1'b0, 3'd6, 5'd1, 1'b0, 4'd2, 16'h0010);
        cmd_ready = 1'b1;
        tick();
        check("cd_done_valid", 32'(cmd_valid), 32'd0);
        check("cd_done_stat",  32'(stat),      32'd1);
        tick();
        check("cd_ready", 32'(ready), 32'd1);

        // 5: illegal opcode, then req while busy
        req = 1'b1; ctrlA = 16'h8000; ctrlB = 16'h0000;
        tick();
        req = 1'b0; ctrlA = 16'h0000;
        tick();                                   // DONE, nothing queued
        check("ill_stat",  32'(stat),      32'd2);
        check("ill_valid", 32'(cmd_valid), 32'd0);
        check("ill_ready", 32'(ready),     32'd0);
        req = 1'b1; ctrlA = 16'h2000;             // req while ready=0
        tick();
        check("busy_stat",  32'(stat),  32'd3);
        check("busy_ready", 32'(ready), 32'd1);
        req = 1'b0; ctrlA = 16'h0000;
        tick();
        check("busy_ign_ready", 32'(ready),     32'd1);
        check("busy_ign_stat",  32'(stat),      32'd0);
        check("busy_ign_valid", 32'(cmd_valid), 32'd0);

        // 6a: set-mode command times out after 15 stalled cycles
        req = 1'b1; ctrlA = 16'h6500; ctrlB = 16'h0000;
        tick();
        req = 1'b0; ctrlA = 16'h1234; cmd_ready = 1'b0;
        tick();                                   // stall cycle 1
        check_cmd("to_s1", 1'b0, 3'd3, 5'd0, 1'b0, 4'd5, 16'h0000);
        repeat (14) tick();                       // stall cycle 15
        check("to_s15_valid", 32'(cmd_valid), 32'd1);
        tick();
        check("to_drop_valid", 32'(cmd_valid), 32'd0);
        check("to_drop_stat",  32'(stat),      32'd3);
        tick();
        check("to_ready", 32'(ready), 32'd1);
        check("to_stat",  32'(stat),  32'd0);

        // 6b: reset pulsed while a command is stalled
        req = 1'b1; ctrlA = 16'hC102; ctrlB = 16'h2240;
        tick();
        req = 1'b0; ctrlA = 16'h0010; ctrlB = 16'h0000;
        tick();
        tick();
        check("mid_valid", 32'(cmd_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid), 32'd0);
        check("arst_ready", 32'(ready),     32'd1);
        check("arst_stat",  32'(stat),      32'd0);
        check("arst_op",    32'(cmd_op),    32'd0);
        check("arst_value", 32'(cmd_value), 32'd0);
        tick();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(cmd_valid), 32'd0);
        check("post_rst_ready", 32'(ready),     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
